// File: rtl/vga_sprite_sched.sv
// Sprite scheduler: shares one synchronous sprite ROM between NUM_SPR priority-ordered
// layers and resolves each pixel to the first opaque layer colour.

module vga_sprite_layer #(
    parameter int SPR_W  = 100,
    parameter int SPR_H  = 100,
    parameter int ADDR_W = 15
) (
    input  logic [10:0]       px,
    input  logic [10:0]       py,
    input  logic              en,
    input  logic [10:0]       x0,
    input  logic [10:0]       y0,
    input  logic [ADDR_W-1:0] base,
    output logic              hit,
    output logic [ADDR_W-1:0] addr
);
    // Box edges at 12 bits so a sprite placed near 2047 does not wrap.
    logic [11:0]       x_end, y_end;
    logic [ADDR_W-1:0] dx, dy;

    assign x_end = {1'b0, x0} + 12'(SPR_W);
    assign y_end = {1'b0, y0} + 12'(SPR_H);
    assign hit   = en && (px >= x0) && ({1'b0, px} < x_end)
                      && (py >= y0) && ({1'b0, py} < y_end);

    assign dx   = ADDR_W'(px - x0);
    assign dy   = ADDR_W'(py - y0);
    assign addr = base + dy * ADDR_W'(SPR_W) + dx;
endmodule

module vga_sprite_sched #(
    parameter int          NUM_SPR  = 4,
    parameter int          SPR_W    = 100,
    parameter int          SPR_H    = 100,
    parameter int          ADDR_W   = 15,
    parameter logic [7:0]  TRANSP   = 8'hE3,
    parameter logic [7:0]  BG_COLOR = 8'h00
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       pix_en,
    input  logic [10:0]                hc,
    input  logic [10:0]                vc,
    input  logic                       blank,
    input  logic                       frame_start,
    input  logic                       cfg_we,
    input  logic [$clog2(NUM_SPR)-1:0] cfg_idx,
    input  logic                       cfg_en,
    input  logic [10:0]                cfg_x0,
    input  logic [10:0]                cfg_y0,
    input  logic [ADDR_W-1:0]          cfg_base,
    output logic [ADDR_W-1:0]          rom_addr,
    input  logic [7:0]                 rom_data,
    output logic [2:0]                 R,
    output logic [2:0]                 G,
    output logic [1:0]                 B,
    output logic                       busy,
    output logic                       overrun
);
    localparam int IDX_W = $clog2(NUM_SPR);

    typedef struct packed {
        logic              en;
        logic [10:0]       x0;
        logic [10:0]       y0;
        logic [ADDR_W-1:0] base;
    } spr_cfg_t;

    typedef enum logic [1:0] {IDLE, SCAN, WAIT, DONE} state_t;

    spr_cfg_t sh_cfg  [NUM_SPR];
    spr_cfg_t act_cfg [NUM_SPR];

    state_t            state;
    logic [IDX_W-1:0]  idx;
    logic [10:0]       px_q, py_q;
    logic [7:0]        col_q, rgb_q;
    logic [ADDR_W-1:0] addr_q;
    logic              overrun_q;

    logic [NUM_SPR-1:0]             layer_hit;
    logic [NUM_SPR-1:0][ADDR_W-1:0] layer_addr;
    logic                           idx_last;

    for (genvar i = 0; i < NUM_SPR; i++) begin : g_layer
        vga_sprite_layer #(
            .SPR_W (SPR_W),
            .SPR_H (SPR_H),
            .ADDR_W(ADDR_W)
        ) u_layer (
            .px  (px_q),
            .py  (py_q),
            .en  (act_cfg[i].en),
            .x0  (act_cfg[i].x0),
            .y0  (act_cfg[i].y0),
            .base(act_cfg[i].base),
            .hit (layer_hit[i]),
            .addr(layer_addr[i])
        );
    end

    assign idx_last = (idx == IDX_W'(NUM_SPR - 1));

    // The address is presented during the SCAN cycle so the synchronous ROM
    // returns data in the following WAIT cycle; otherwise the last address holds.
    assign rom_addr  = (state == SCAN && layer_hit[idx]) ? layer_addr[idx] : addr_q;
    assign {R, G, B} = rgb_q;
    assign busy      = (state != IDLE);
    assign overrun   = overrun_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            px_q      <= '0;
            py_q      <= '0;
            col_q     <= '0;
            rgb_q     <= '0;
            addr_q    <= '0;
            overrun_q <= 1'b0;
            for (int i = 0; i < NUM_SPR; i++) begin
                sh_cfg[i]  <= '0;
                act_cfg[i] <= '0;
            end
        end else begin
            if (frame_start)
                for (int i = 0; i < NUM_SPR; i++) act_cfg[i] <= sh_cfg[i];
            if (cfg_we && int'(cfg_idx) < NUM_SPR)
                sh_cfg[cfg_idx] <= '{en: cfg_en, x0: cfg_x0, y0: cfg_y0, base: cfg_base};

            if (pix_en) begin
                // A pixel arriving mid-scan aborts the old one to background.
                if (state != IDLE) begin
                    rgb_q     <= BG_COLOR;
                    overrun_q <= 1'b1;
                end
                px_q <= hc;
                py_q <= vc;
                idx  <= '0;
                if (blank) begin
                    col_q <= 8'h00;
                    state <= DONE;
                end else begin
                    state <= SCAN;
                end
            end else begin
                case (state)
                    SCAN: begin
                        if (layer_hit[idx]) begin
                            addr_q <= layer_addr[idx];
                            state  <= WAIT;
                        end else if (idx_last) begin
                            col_q <= BG_COLOR;
                            state <= DONE;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                    WAIT: begin
                        if (rom_data != TRANSP) begin
                            col_q <= rom_data;
                            state <= DONE;
                        end else if (idx_last) begin
                            col_q <= BG_COLOR;
                            state <= DONE;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= SCAN;
                        end
                    end
                    DONE: begin
                        rgb_q <= col_q;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_vga_sprite_sched.sv
// Bench for vga_sprite_sched: directed pixels, expected colours queued at issue and
// popped by a monitor whenever the scheduler delivers a colour.

module tb_vga_sprite_sched;
    localparam logic [7:0] TRANSP = 8'hE3;
    localparam logic [7:0] BG     = 8'h00;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pix_en, blank, frame_start, cfg_we, cfg_en;
    logic [10:0] hc, vc, cfg_x0, cfg_y0;
    logic [1:0]  cfg_idx;
    logic [14:0] cfg_base, rom_addr;
    logic [7:0]  rom_data;
    logic [2:0]  R, G;
    logic [1:0]  B;
    logic        busy, overrun;

    always #5 clk = ~clk;

    vga_sprite_sched dut (
        .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .hc(hc), .vc(vc), .blank(blank),
        .frame_start(frame_start), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_en(cfg_en),
        .cfg_x0(cfg_x0), .cfg_y0(cfg_y0), .cfg_base(cfg_base), .rom_addr(rom_addr),
        .rom_data(rom_data), .R(R), .G(G), .B(B), .busy(busy), .overrun(overrun)
    );

    // Sprite ROM image; unlisted addresses read as a fixed opaque colour.
    logic [7:0] rom_img [int];
    function automatic logic [7:0] rom_lookup(input int a);
        if (rom_img.exists(a)) return rom_img[a];
        return 8'h55;
    endfunction
    always @(posedge clk) rom_data <= rom_lookup(int'(rom_addr));

    int         n_cmp = 0, n_err = 0;
    logic [7:0] exp_q [$];
    string      name_q [$];
    logic       ab, bw;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic expect_rgb(input logic [7:0] v, input string nm);
        exp_q.push_back(v);
        name_q.push_back(nm);
    endtask

    // A colour is delivered when busy falls, or at once when a pixel aborts a scan.
    always begin
        @(posedge clk);
        ab = rst_n && pix_en && busy;
        bw = rst_n && busy;
        @(negedge clk);
        if (rst_n && (ab || (bw && !busy))) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL rgb_unexpected: got %0h, expected no output", {R, G, B});
            end else begin
                automatic logic [7:0] e  = exp_q.pop_front();
                automatic string      nm = name_q.pop_front();
                chk(nm, {R, G, B}, e);
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic pix(input int h, input int v, input logic b);
        pix_en = 1'b1; hc = 11'(h); vc = 11'(v); blank = b;
        tick();
        pix_en = 1'b0; blank = 1'b0;
    endtask

    task automatic cfg_wr(input int i, input logic en, input int x, input int y,
                          input int base, input logic fs);
        cfg_we = 1'b1; cfg_idx = 2'(i); cfg_en = en;
        cfg_x0 = 11'(x); cfg_y0 = 11'(y); cfg_base = 15'(base); frame_start = fs;
        tick();
        cfg_we = 1'b0; frame_start = 1'b0;
    endtask

    task automatic fs();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; pix_en = 0; blank = 0; frame_start = 0; cfg_we = 0; cfg_en = 0;
        hc = '0; vc = '0; cfg_x0 = '0; cfg_y0 = '0; cfg_idx = '0; cfg_base = '0;
        rom_img[205]   = 8'h1C;
        rom_img[505]   = 8'h3A;
        rom_img[1010]  = TRANSP;
        rom_img[11010] = 8'hC0;
        @(negedge clk);
        repeat (2) begin
            pix_en = 1'($urandom); blank = 1'($urandom); frame_start = 1'($urandom);
            cfg_we = 1'($urandom); cfg_en = 1'($urandom); hc = 11'($urandom);
            vc = 11'($urandom); cfg_x0 = 11'($urandom); cfg_y0 = 11'($urandom);
            cfg_idx = 2'($urandom); cfg_base = 15'($urandom);
            tick();
        end
        chk("reset_R", R, 0);
        chk("reset_G", G, 0);
        chk("reset_B", B, 0);
        chk("reset_rom_addr", rom_addr, 0);
        chk("reset_busy", busy, 0);
        chk("reset_overrun", overrun, 0);
        pix_en = 0; blank = 0; frame_start = 0; cfg_we = 0; rst_n = 1'b1;
        tick(2);

        // Single layer hit and 3-clk latency
        cfg_wr(0, 1, 100, 50, 0, 0);
        fs();
        expect_rgb(8'h1C, "single_hit");
        pix(105, 52, 0);
        chk("addr_single", rom_addr, 205);
        tick(3);
        chk("rgb_latency3", {R, G, B}, 8'h1C);
        chk("busy_after", busy, 0);
        tick(8);

        // Miss on every layer: background, no ROM access
        expect_rgb(BG, "miss_bg");
        pix(200, 52, 0);
        tick(2);
        chk("addr_hold_miss", rom_addr, 205);
        tick(8);

        // Shadow vs active configuration
        cfg_wr(0, 1, 300, 300, 0, 0);
        expect_rgb(8'h1C, "shadow_no_fs");
        pix(105, 52, 0);
        tick(10);
        fs();
        expect_rgb(BG, "shadow_after_fs");
        pix(105, 52, 0);
        tick(10);
        cfg_wr(0, 1, 100, 50, 0, 1);
        expect_rgb(8'h3A, "same_cycle_old");
        pix(305, 305, 0);
        tick(10);
        fs();
        expect_rgb(8'h1C, "second_fs");
        pix(105, 52, 0);
        tick(10);

        // Priority with transparent top layer
        cfg_wr(0, 1, 0, 0, 0, 0);
        cfg_wr(1, 1, 0, 0, 10000, 0);
        fs();
        expect_rgb(8'hC0, "prio_transp");
        pix(10, 10, 0);
        chk("addr_layer0", rom_addr, 1010);
        tick(2);
        chk("addr_layer1", rom_addr, 11010);
        tick(8);

        // Blank pixel over a sprite
        expect_rgb(8'h00, "blank");
        pix(10, 10, 1);
        tick(1);
        chk("rgb_blank_2clk", {R, G, B}, 8'h00);
        chk("addr_blank_hold", rom_addr, 11010);
        tick(5);

        expect_rgb(8'hC0, "prio_again");
        pix(10, 10, 0);
        tick(10);

        // Overrun: second pixel 3 clk after the first, both layers transparent
        chk("overrun_pre", overrun, 0);
        rom_img[11010] = TRANSP;
        expect_rgb(BG, "abort_bg");
        pix(10, 10, 0);
        tick(2);
        expect_rgb(BG, "after_abort");
        pix(10, 10, 0);
        tick(12);
        chk("overrun_set", overrun, 1);
        tick(10);
        chk("overrun_sticky", overrun, 1);
        chk("busy_final", busy, 0);

        chk("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
